// File: rtl/rvc_fetch_pkg.sv
// Shared types, constants and helpers for the RVC fetch aligner.
package rvc_fetch_pkg;

    localparam int          HW_W     = 16;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // A halfword starts a 32-bit instruction only when its two LSBs are 2'b11.
    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return (hw & 16'h0003) != 16'h0003;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/hw_queue.sv
// Halfword FIFO: pushes and pops 0, 1 or 2 halfwords per cycle, exposes the two oldest entries.
module hw_queue
    import rvc_fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic [1:0]               push_n_i,
    input  logic [HW_W-1:0]          push_d0_i,
    input  logic [HW_W-1:0]          push_d1_i,
    input  logic [1:0]               pop_n_i,
    output logic [cnt_w(DEPTH)-1:0]  count_o,
    output logic [HW_W-1:0]          h0_o,
    output logic [HW_W-1:0]          h1_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr1, rd1;

    assign wr1 = wr_q + PW'(1);
    assign rd1 = rd_q + PW'(1);

    always_comb begin
        wr_d  = wr_q + PW'(push_n_i);
        rd_d  = rd_q + PW'(pop_n_i);
        cnt_d = cnt_q + CW'(push_n_i) - CW'(pop_n_i);
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed below count.
    always_ff @(posedge clk) begin
        if (rst_n && !clr_i) begin
            if (push_n_i != 2'd0) mem_q[wr_q] <= push_d0_i;
            if (push_n_i == 2'd2) mem_q[wr1]  <= push_d1_i;
        end
    end

    assign count_o = cnt_q;
    assign h0_o    = mem_q[rd_q];
    assign h1_o    = mem_q[rd1];

endmodule

// File: rtl/rvc_fetch_aligner.sv
// RVC fetch front-end: issues word fetches, drops stale responses after a redirect,
// and aligns mixed 16/32-bit instructions out of a halfword prefetch queue.
module rvc_fetch_aligner
    import rvc_fetch_pkg::*;
#(
    parameter int          DEPTH_HW    = 8,
    parameter int          MAX_OUT     = 2,
    parameter bit          BYTE_SWAP   = 1'b1,
    parameter bit          ZERO_AS_NOP = 1'b1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [29:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_rvc,
    output logic [31:0] out_pc,
    output logic        busy
);

    localparam int CW = cnt_w(DEPTH_HW);
    localparam int OW = cnt_w(MAX_OUT);

    logic [29:0]     fetch_ptr_q, fetch_ptr_d;
    logic [31:0]     head_pc_q, head_pc_d;
    logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;
    logic            skip_q, skip_d;

    logic [CW-1:0]   count;
    logic [HW_W-1:0] h0, h1, d0, d1;
    logic [31:0]     word;
    logic [1:0]      push_n, pop_n;
    logic            issue, accept, rvc, inst_ok, pop;
    logic            unused_pc0;

    assign unused_pc0 = redirect_pc[0];

    // Reserve queue room for every word already in flight, so a response can always be pushed.
    assign req_valid = rst_n && !redirect && (int'(outst_q) < MAX_OUT)
                       && (int'(count) + 2 * int'(outst_q) + 2 <= DEPTH_HW);
    assign req_addr  = fetch_ptr_q;
    assign issue     = req_valid && req_ready;

    always_comb begin
        word = BYTE_SWAP ? bswap32(rsp_data) : rsp_data;
        if (ZERO_AS_NOP && word == 32'h0) word = NOP_INST;
    end

    assign accept = rsp_valid && !redirect && (drop_q == '0);
    assign push_n = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    assign d0     = skip_q ? word[31:16] : word[15:0];
    assign d1     = word[31:16];

    hw_queue #(.DEPTH(DEPTH_HW)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (redirect),
        .push_n_i  (push_n),
        .push_d0_i (d0),
        .push_d1_i (d1),
        .pop_n_i   (pop_n),
        .count_o   (count),
        .h0_o      (h0),
        .h1_o      (h1)
    );

    assign rvc       = is_rvc(h0);
    assign inst_ok   = rvc ? (int'(count) >= 1) : (int'(count) >= 2);
    assign out_valid = rst_n && !redirect && inst_ok;
    assign pop       = out_valid && out_ready;
    assign pop_n     = pop ? (rvc ? 2'd1 : 2'd2) : 2'd0;

    assign out_inst  = !rst_n ? 32'h0 : (rvc ? {16'h0, h0} : {h1, h0});
    assign out_rvc   = rst_n && rvc;
    assign out_pc    = rst_n ? head_pc_q : RESET_PC;
    assign busy      = rst_n && (outst_q != '0 || drop_q != '0);

    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        head_pc_d   = head_pc_q;
        drop_d      = drop_q;
        skip_d      = skip_q;
        outst_d     = outst_q + OW'(issue) - OW'(rsp_valid);
        if (redirect) begin
            // Everything still in flight (minus this cycle's word) belongs to the old stream.
            head_pc_d   = {redirect_pc[31:1], 1'b0};
            fetch_ptr_d = redirect_pc[31:2];
            skip_d      = redirect_pc[1];
            drop_d      = outst_q - OW'(rsp_valid);
        end else begin
            if (issue)                     fetch_ptr_d = fetch_ptr_q + 30'd1;
            if (pop)                       head_pc_d   = head_pc_q + (rvc ? 32'd2 : 32'd4);
            if (rsp_valid && drop_q != '0) drop_d      = drop_q - OW'(1);
            if (accept)                    skip_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_ptr_q <= RESET_PC[31:2];
            head_pc_q   <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            skip_q      <= RESET_PC[1];
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            head_pc_q   <= head_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            skip_q      <= skip_d;
        end
    end

endmodule
